// File: rtl/mips_cache_pkg.sv
// Shared types and geometry helpers for the N-way instruction cache controller.
package mips_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } cache_state_e;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets, input int line_words);
        return 30 - $clog2(sets) - $clog2(line_words);
    endfunction

    // A single way still needs a one-bit pointer/way field.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [63:0] max_v;
        max_v = (64'd1 << w) - 64'd1;
        return ({32'd0, v} >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag storage and round-robin victim pointers per set.
// Combinational read of one set, one line write port, bulk flush.
module icache_tag_array
    import mips_cache_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    localparam int IDX_W     = idx_w(SETS),
    localparam int TAG_W     = tag_w(SETS, LINE_WORDS),
    localparam int WAY_W     = way_w(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_all,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [WAYS-1:0]       rd_valid,
    output logic [WAYS*TAG_W-1:0] rd_tags,
    output logic [WAY_W-1:0]      rd_rr,
    input  logic                  rr_adv,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [WAY_W-1:0]      wr_way,
    input  logic [TAG_W-1:0]      wr_tag
);

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  valid_d [SETS];
    logic [WAY_W-1:0] rr_q    [SETS];
    logic [WAY_W-1:0] rr_d    [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [TAG_W-1:0] tag_d   [SETS][WAYS];

    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_rr    = rr_q[rd_idx];
        rd_tags  = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_tags[w*TAG_W +: TAG_W] = tag_q[rd_idx][w];
        end
    end

    always_comb begin
        valid_d = valid_q;
        rr_d    = rr_q;
        tag_d   = tag_q;
        if (wr_en) begin
            valid_d[wr_idx][wr_way] = 1'b1;
            tag_d[wr_idx][wr_way]   = wr_tag;
        end
        if (rr_adv) begin
            rr_d[rd_idx] = (WAYS > 1) ? rr_q[rd_idx] + 1'b1 : '0;
        end
        // Flush wins over a same-edge pointer advance.
        if (flush_all) begin
            for (int s = 0; s < SETS; s++) begin
                valid_d[s] = '0;
                rr_d[s]    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

endmodule

// File: rtl/icache_nway_ctrl.sv
// N-way set-associative I-cache controller: 0-cycle hit, multi-beat refill,
// stall from miss detect through last beat, saturating hit/miss counters.
module icache_nway_ctrl
    import mips_cache_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RD_EN,
    input  logic [31:0]      ADDR,
    input  logic             FLUSH,
    input  logic             CNT_CLR,
    output logic [31:0]      DATA,
    output logic             HIT,
    output logic             STALL,
    output logic             MM_REQ,
    output logic [31:0]      MM_ADDR,
    input  logic             MM_VALID,
    input  logic [31:0]      MM_DATA,
    output logic [CNT_W-1:0] CNT_HIT,
    output logic [CNT_W-1:0] CNT_MISS
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(SETS, LINE_WORDS);
    localparam int WAY_W  = way_w(WAYS);
    localparam int DA_W   = $clog2(SETS * WAYS * LINE_WORDS);

    cache_state_e       state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [IDX_W-1:0]   req_idx_q, req_idx_d;
    logic [TAG_W-1:0]   req_tag_q, req_tag_d;
    logic [OFF_WS-1:0]  req_off_q, req_off_d;
    logic [OFF_WS-1:0]  beat_q, beat_d;
    logic [31:0]        req_word_q, req_word_d;
    logic               flush_pend_q, flush_pend_d;
    logic [31:0]        mm_addr_q, mm_addr_d;
    logic [CNT_W-1:0]   cnt_hit_q, cnt_hit_d;
    logic [CNT_W-1:0]   cnt_miss_q, cnt_miss_d;
    logic [31:0]        data_q [SETS*WAYS*LINE_WORDS];

    logic [IDX_W-1:0]      a_idx;
    logic [OFF_WS-1:0]     a_off;
    logic [TAG_W-1:0]      a_tag;
    logic [WAYS-1:0]       rd_valid;
    logic [WAYS*TAG_W-1:0] rd_tags;
    logic [WAY_W-1:0]      rd_rr, hit_way, inv_way;
    logic                  lk_hit, any_inv, rr_adv, flush_all, tag_wr, dwr_en;
    logic [DA_W-1:0]       rd_addr, wr_addr;

    assign a_off = OFF_WS'((ADDR >> 2) & 32'(LINE_WORDS - 1));
    assign a_idx = IDX_W'(ADDR >> (2 + OFF_W));
    assign a_tag = TAG_W'(ADDR >> (2 + OFF_W + IDX_W));

    icache_tag_array #(
        .SETS       (SETS),
        .WAYS       (WAYS),
        .LINE_WORDS (LINE_WORDS)
    ) u_tags (
        .clk       (CLK),
        .rst       (RESET),
        .flush_all (flush_all),
        .rd_idx    (a_idx),
        .rd_valid  (rd_valid),
        .rd_tags   (rd_tags),
        .rd_rr     (rd_rr),
        .rr_adv    (rr_adv),
        .wr_en     (tag_wr),
        .wr_idx    (req_idx_q),
        .wr_way    (victim_q),
        .wr_tag    (req_tag_q)
    );

    // Descending scan leaves the lowest-index invalid way in inv_way.
    always_comb begin
        lk_hit  = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_valid[w] && (rd_tags[w*TAG_W +: TAG_W] == a_tag)) begin
                lk_hit  = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!rd_valid[w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        rd_addr = DA_W'((int'(a_idx) * WAYS + int'(hit_way)) * LINE_WORDS + int'(a_off));
        wr_addr = DA_W'((int'(req_idx_q) * WAYS + int'(victim_q)) * LINE_WORDS + int'(beat_q));
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        req_idx_d    = req_idx_q;
        req_tag_d    = req_tag_q;
        req_off_d    = req_off_q;
        beat_d       = beat_q;
        req_word_d   = req_word_q;
        flush_pend_d = flush_pend_q;
        mm_addr_d    = mm_addr_q;
        cnt_hit_d    = cnt_hit_q;
        cnt_miss_d   = cnt_miss_q;
        HIT          = 1'b0;
        STALL        = 1'b0;
        DATA         = '0;
        rr_adv       = 1'b0;
        flush_all    = 1'b0;
        tag_wr       = 1'b0;
        dwr_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                flush_all = FLUSH;
                if (RD_EN) begin
                    if (lk_hit) begin
                        HIT       = 1'b1;
                        DATA      = data_q[rd_addr];
                        cnt_hit_d = CNT_W'(sat_inc(32'(cnt_hit_q), CNT_W));
                    end else begin
                        STALL        = 1'b1;
                        victim_d     = any_inv ? inv_way : rd_rr;
                        rr_adv       = !any_inv;
                        req_idx_d    = a_idx;
                        req_tag_d    = a_tag;
                        req_off_d    = a_off;
                        beat_d       = '0;
                        flush_pend_d = 1'b0;
                        mm_addr_d    = ADDR & ~(32'(LINE_WORDS) * 32'd4 - 32'd1);
                        cnt_miss_d   = CNT_W'(sat_inc(32'(cnt_miss_q), CNT_W));
                        state_d      = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                STALL = 1'b1;
                if (FLUSH) begin
                    flush_pend_d = 1'b1;
                end
                if (MM_VALID) begin
                    dwr_en = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == req_off_q) begin
                        req_word_d = MM_DATA;
                    end
                    if (beat_q == OFF_WS'(LINE_WORDS - 1)) begin
                        tag_wr  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                DATA         = req_word_q;
                flush_all    = flush_pend_q | FLUSH;
                flush_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (CNT_CLR) begin
            cnt_hit_d  = '0;
            cnt_miss_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            victim_q     <= '0;
            req_idx_q    <= '0;
            req_tag_q    <= '0;
            req_off_q    <= '0;
            beat_q       <= '0;
            req_word_q   <= '0;
            flush_pend_q <= 1'b0;
            mm_addr_q    <= '0;
            cnt_hit_q    <= '0;
            cnt_miss_q   <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            req_idx_q    <= req_idx_d;
            req_tag_q    <= req_tag_d;
            req_off_q    <= req_off_d;
            beat_q       <= beat_d;
            req_word_q   <= req_word_d;
            flush_pend_q <= flush_pend_d;
            mm_addr_q    <= mm_addr_d;
            cnt_hit_q    <= cnt_hit_d;
            cnt_miss_q   <= cnt_miss_d;
        end
    end

    // Line data is never reset; validity lives in the tag array.
    always_ff @(posedge CLK) begin
        if (dwr_en) begin
            data_q[wr_addr] <= MM_DATA;
        end
    end

    assign MM_REQ   = (state_q == ST_REFILL);
    assign MM_ADDR  = mm_addr_q;
    assign CNT_HIT  = cnt_hit_q;
    assign CNT_MISS = cnt_miss_q;

endmodule
